// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver that packs WIDTH/8 bytes into one word
// Bytes fill the word LSB-first; stop-bit errors drop the partial word.
module uart_receiver #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int H      = CLKS_PER_BIT / 2;
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, next_state;
  logic             s_meta, s;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [BW-1:0]    byte_idx;
  logic [7:0]       shreg;
  logic [WIDTH-1:0] asm_word, word_next;
  logic             tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      state  <= IDLE;
    end else begin
      s_meta <= din;
      s      <= s_meta;
      state  <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tick       = 1'b0;
    case (state)
      IDLE:  if (!s) next_state = START;
      START: if (cnt == CNT_HALF) begin
        tick       = 1'b1;
        next_state = s ? IDLE : DATA;
      end
      DATA:  if (cnt == CNT_LAST) begin
        tick = 1'b1;
        if (bit_idx == 3'd7) next_state = STOP;
      end
      STOP:  if (cnt == CNT_LAST) begin
        tick       = 1'b1;
        next_state = s ? IDLE : BREAK;
      end
      BREAK: if (s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Assembled word with the just-received byte merged in at the current slot
  always_comb begin
    word_next = asm_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_idx == BW'(b)) word_next[b*8 +: 8] = shreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      asm_word <= '0;
      dout     <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (state == IDLE || state == BREAK || tick) cnt <= '0;
      else                                         cnt <= cnt + CW'(1);
      if (tick) begin
        case (state)
          START: bit_idx <= '0;
          DATA: begin
            shreg[bit_idx] <= s;
            bit_idx        <= bit_idx + 3'd1;
          end
          STOP: begin
            if (s) begin
              asm_word <= word_next;
              if (byte_idx == BYTE_LAST) begin
                dout     <= word_next;
                valid    <= 1'b1;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + BW'(1);
              end
            end else begin
              err      <= 1'b1;
              byte_idx <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE) || (byte_idx != '0);

endmodule
